// File: rtl/smu_cfg_ctrl.sv
// smu_cfg_ctrl
//   Loads the SMU configuration bitstream serially, unpacks it into the
//   per-SMU comparator / mask / compare-select / FSM-target registers, and
//   raises the shared SMU enable once the whole stream is in. Per-SMU
//   trigger outputs are captured into sticky status bits.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   cfg_start         pulse: begin (re)loading the bitstream
//   cfg_stop          pulse: disable SMUs, go idle (beats start / completion)
//   cfg_valid/data    serial config bit, taken when cfg_valid & cfg_ready
//   cfg_ready         high while loading
//   cfg_done          one-cycle pulse after the last bit is taken
//   cfg_error         sticky: a load was restarted before completing
//   reg_cmp_mask      SMU j at [j*K +: K]
//   reg_cmp           SMU j at [j*K +: K]
//   reg_cmp_sel       SMU j at [j*2 +: 2]
//   reg_fsm_cmp       SMU j at [j*SW +: SW]
//   smu_en            shared SMU enable
//   trig_in/clr       SMU trigger inputs, status clear
//   trig_status/any   sticky per-SMU capture and its registered OR

module smu_trig_lane (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic trig,
  input  logic clr,
  output logic status
);
  // A set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst)              status <= 1'b0;
    else if (trig && en)  status <= 1'b1;
    else if (clr)         status <= 1'b0;
  end
endmodule

module smu_cfg_ctrl #(
  parameter  int NUM_SMU = 2,
  parameter  int N       = 2,
  parameter  int K       = 4,
  localparam int SW      = ($clog2(N) > 1) ? $clog2(N) : 1,
  localparam int W       = 2*K + 2 + SW,
  localparam int TOTAL   = NUM_SMU * W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic                  cfg_stop,
  input  logic                  cfg_valid,
  input  logic                  cfg_data,
  output logic                  cfg_ready,
  output logic                  cfg_done,
  output logic                  cfg_error,
  output logic [NUM_SMU*K-1:0]  reg_cmp_mask,
  output logic [NUM_SMU*K-1:0]  reg_cmp,
  output logic [NUM_SMU*2-1:0]  reg_cmp_sel,
  output logic [NUM_SMU*SW-1:0] reg_fsm_cmp,
  output logic                  smu_en,
  input  logic [NUM_SMU-1:0]    trig_in,
  input  logic                  trig_clr,
  output logic [NUM_SMU-1:0]    trig_status,
  output logic                  trig_any
);
  localparam int CW = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {IDLE, LOAD, ACTIVE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [TOTAL-1:0] cfg_vec;
  logic             accept;

  // cfg_ready is exactly "in LOAD", so this is the handshake.
  assign accept = cfg_valid && cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cfg_vec   <= '0;
      cfg_ready <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_error <= 1'b0;
      smu_en    <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      // Shift LSB-first; an accepted bit always shifts, even when a
      // restart or stop in the same cycle throws away its count.
      if (accept) cfg_vec <= {cfg_data, cfg_vec[TOTAL-1:1]};

      if (cfg_stop) begin
        state     <= IDLE;
        cfg_ready <= 1'b0;
        smu_en    <= 1'b0;
      end else if (cfg_start) begin
        if (state == LOAD) cfg_error <= 1'b1;
        state     <= LOAD;
        cnt       <= '0;
        cfg_ready <= 1'b1;
        smu_en    <= 1'b0;
      end else if (state == LOAD && accept) begin
        if (cnt == CW'(TOTAL - 1)) begin
          state     <= ACTIVE;
          cfg_ready <= 1'b0;
          smu_en    <= 1'b1;
          cfg_done  <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Field unpacking straight off the shift register.
  for (genvar j = 0; j < NUM_SMU; j++) begin : g_unpack
    assign reg_cmp_mask[j*K +: K]  = cfg_vec[j*W +: K];
    assign reg_cmp[j*K +: K]       = cfg_vec[j*W + K +: K];
    assign reg_cmp_sel[j*2 +: 2]   = cfg_vec[j*W + 2*K +: 2];
    assign reg_fsm_cmp[j*SW +: SW] = cfg_vec[j*W + 2*K + 2 +: SW];
  end

  // A new load also starts with clean trigger status.
  logic trig_clr_int;
  assign trig_clr_int = trig_clr || cfg_start;

  smu_trig_lane u_lane [NUM_SMU-1:0] (
    .clk    (clk),
    .rst    (rst),
    .en     (smu_en),
    .trig   (trig_in),
    .clr    (trig_clr_int),
    .status (trig_status)
  );

  always_ff @(posedge clk) begin
    if (rst) trig_any <= 1'b0;
    else     trig_any <= |trig_status;
  end
endmodule

// File: tb/tb_smu_cfg_ctrl.sv
module tb_smu_cfg_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start, cfg_stop, cfg_valid, cfg_data;
  logic       cfg_ready, cfg_done, cfg_error;
  logic [7:0] reg_cmp_mask, reg_cmp;
  logic [3:0] reg_cmp_sel;
  logic [1:0] reg_fsm_cmp;
  logic       smu_en;
  logic [1:0] trig_in;
  logic       trig_clr;
  logic [1:0] trig_status;
  logic       trig_any;

  int n_cmp = 0;
  int n_bad = 0;

  // Pattern A: SMU0 {fsm=1,sel=01,cmp=A,mask=F}=11'h5AF, SMU1 {0,10,1,3}=11'h213
  logic [21:0] pat_a;
  // Pattern B: the two words swapped
  logic [21:0] pat_b;

  always #5 clk = ~clk;

  smu_cfg_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_valid    (cfg_valid),
    .cfg_data     (cfg_data),
    .cfg_ready    (cfg_ready),
    .cfg_done     (cfg_done),
    .cfg_error    (cfg_error),
    .reg_cmp_mask (reg_cmp_mask),
    .reg_cmp      (reg_cmp),
    .reg_cmp_sel  (reg_cmp_sel),
    .reg_fsm_cmp  (reg_fsm_cmp),
    .smu_en       (smu_en),
    .trig_in      (trig_in),
    .trig_clr     (trig_clr),
    .trig_status  (trig_status),
    .trig_any     (trig_any)
  );

  // Stimulus helpers: inputs change at negedge; outputs read at negedge.
  task automatic pulse_start();
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic send_bits(input logic [21:0] pat, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = pat[i];
      @(negedge clk);
    end
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1; trig_in = 2'b11;
    cfg_start = 1'b0; cfg_stop = 1'b0; trig_clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({reg_cmp_mask, reg_cmp, reg_cmp_sel, reg_fsm_cmp} !== 22'h0) begin
      n_bad++; $display("FAIL reset_regs: got %h want 0", {reg_cmp_mask, reg_cmp, reg_cmp_sel, reg_fsm_cmp}); end
    n_cmp++; if ({smu_en, cfg_ready, cfg_done, cfg_error} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_ctrl: got %b want 0000", {smu_en, cfg_ready, cfg_done, cfg_error}); end
    n_cmp++; if ({trig_status, trig_any} !== 3'b000) begin
      n_bad++; $display("FAIL reset_trig: got %b want 000", {trig_status, trig_any}); end
    rst = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0; trig_in = 2'b00;
    @(negedge clk);
    n_cmp++; if ({smu_en, cfg_ready, trig_status} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_idle: got %b want 0000", {smu_en, cfg_ready, trig_status}); end
  endtask

  task automatic test_full_load();
    int cyc;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    cyc = 1;
    n_cmp++; if ({cfg_ready, smu_en} !== 2'b10) begin
      n_bad++; $display("FAIL load_ready: got %b want 10", {cfg_ready, smu_en}); end
    for (int i = 0; i < 22; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = pat_a[i];
      @(negedge clk);
      cyc++;
      if (i == 20) begin
        n_cmp++; if ({smu_en, cfg_done} !== 2'b00) begin
          n_bad++; $display("FAIL load_early_en cyc%0d: got %b want 00", cyc, {smu_en, cfg_done}); end
      end
    end
    cfg_valid = 1'b0;
    // cyc == 23 here: enable must appear exactly 23 cycles after start
    n_cmp++; if ({smu_en, cfg_done, cfg_ready} !== 3'b110) begin
      n_bad++; $display("FAIL load_done cyc%0d: got %b want 110", cyc, {smu_en, cfg_done, cfg_ready}); end
    @(negedge clk);
    n_cmp++; if ({smu_en, cfg_done} !== 2'b10) begin
      n_bad++; $display("FAIL load_done_pulse: got %b want 10", {smu_en, cfg_done}); end
    n_cmp++; if (reg_cmp_mask !== 8'h3F) begin
      n_bad++; $display("FAIL load_mask: got %h want 3f", reg_cmp_mask); end
    n_cmp++; if (reg_cmp !== 8'h1A) begin
      n_bad++; $display("FAIL load_cmp: got %h want 1a", reg_cmp); end
    n_cmp++; if (reg_cmp_sel !== 4'b1001) begin
      n_bad++; $display("FAIL load_sel: got %b want 1001", reg_cmp_sel); end
    n_cmp++; if (reg_fsm_cmp !== 2'b01) begin
      n_bad++; $display("FAIL load_fsm: got %b want 01", reg_fsm_cmp); end
  endtask

  task automatic test_stalled_load();
    // Clear the registers first so identical data must actually be reloaded.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++; if (reg_cmp_mask !== 8'h00) begin
      n_bad++; $display("FAIL stall_pre_clear: got %h want 00", reg_cmp_mask); end
    pulse_start();
    for (int i = 0; i < 22; i++) begin
      cfg_valid = 1'b1;
      cfg_data  = pat_a[i];
      @(negedge clk);
      if (i == 21) begin
        n_cmp++; if ({smu_en, cfg_done} !== 2'b11) begin
          n_bad++; $display("FAIL stall_done: got %b want 11", {smu_en, cfg_done}); end
      end
      cfg_valid = 1'b0;
      cfg_data  = ~pat_a[i];  // garbage while invalid must not shift
      @(negedge clk);
      if (i == 20) begin
        n_cmp++; if (smu_en !== 1'b0) begin
          n_bad++; $display("FAIL stall_early_en: got %b want 0", smu_en); end
      end
    end
    n_cmp++; if ({reg_cmp_mask, reg_cmp, reg_cmp_sel, reg_fsm_cmp} !== {8'h3F, 8'h1A, 4'b1001, 2'b01}) begin
      n_bad++; $display("FAIL stall_regs: got %h want %h",
        {reg_cmp_mask, reg_cmp, reg_cmp_sel, reg_fsm_cmp}, {8'h3F, 8'h1A, 4'b1001, 2'b01}); end
  endtask

  task automatic test_restart();
    logic [21:0] ones;
    ones = '1;
    pulse_start();
    send_bits(ones, 0, 9);
    n_cmp++; if (cfg_error !== 1'b0) begin
      n_bad++; $display("FAIL restart_pre_err: got %b want 0", cfg_error); end
    // Restart with a bit offered in the same cycle: it shifts but is not counted.
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0; cfg_valid = 1'b0;
    n_cmp++; if ({cfg_error, cfg_ready, smu_en} !== 3'b110) begin
      n_bad++; $display("FAIL restart_err: got %b want 110", {cfg_error, cfg_ready, smu_en}); end
    send_bits(pat_b, 0, 20);
    n_cmp++; if (smu_en !== 1'b0) begin
      n_bad++; $display("FAIL restart_early_en: got %b want 0", smu_en); end
    send_bits(pat_b, 21, 21);
    n_cmp++; if ({smu_en, cfg_done, cfg_error} !== 3'b111) begin
      n_bad++; $display("FAIL restart_done: got %b want 111", {smu_en, cfg_done, cfg_error}); end
    n_cmp++; if ({reg_cmp_mask, reg_cmp, reg_cmp_sel, reg_fsm_cmp} !== {8'hF3, 8'hA1, 4'b0110, 2'b10}) begin
      n_bad++; $display("FAIL restart_regs: got %h want %h",
        {reg_cmp_mask, reg_cmp, reg_cmp_sel, reg_fsm_cmp}, {8'hF3, 8'hA1, 4'b0110, 2'b10}); end
  endtask

  task automatic test_stop_priority();
    cfg_stop = 1'b1; cfg_start = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0; cfg_start = 1'b0;
    n_cmp++; if ({smu_en, cfg_ready} !== 2'b00) begin
      n_bad++; $display("FAIL stop_start: got %b want 00", {smu_en, cfg_ready}); end
    @(negedge clk);
    n_cmp++; if ({reg_cmp_mask, reg_cmp, reg_cmp_sel, reg_fsm_cmp} !== {8'hF3, 8'hA1, 4'b0110, 2'b10}) begin
      n_bad++; $display("FAIL stop_regs_kept: got %h want %h",
        {reg_cmp_mask, reg_cmp, reg_cmp_sel, reg_fsm_cmp}, {8'hF3, 8'hA1, 4'b0110, 2'b10}); end
    n_cmp++; if ({smu_en, cfg_ready, cfg_error} !== 3'b001) begin
      n_bad++; $display("FAIL stop_idle: got %b want 001", {smu_en, cfg_ready, cfg_error}); end
    // Stop on the final bit: no completion
    pulse_start();
    send_bits(pat_a, 0, 20);
    cfg_valid = 1'b1; cfg_data = pat_a[21]; cfg_stop = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; cfg_stop = 1'b0;
    n_cmp++; if ({smu_en, cfg_done, cfg_ready} !== 3'b000) begin
      n_bad++; $display("FAIL stop_last_bit: got %b want 000", {smu_en, cfg_done, cfg_ready}); end
    @(negedge clk);
    n_cmp++; if ({smu_en, cfg_done} !== 2'b00) begin
      n_bad++; $display("FAIL stop_last_bit_after: got %b want 00", {smu_en, cfg_done}); end
  endtask

  task automatic test_triggers();
    pulse_start();
    send_bits(pat_a, 0, 21);
    n_cmp++; if (smu_en !== 1'b1) begin
      n_bad++; $display("FAIL trig_setup_en: got %b want 1", smu_en); end
    trig_in = 2'b10;
    @(negedge clk);
    trig_in = 2'b00;
    n_cmp++; if ({trig_status, trig_any} !== 3'b100) begin
      n_bad++; $display("FAIL trig_set: got %b want 100", {trig_status, trig_any}); end
    @(negedge clk);
    n_cmp++; if ({trig_status, trig_any} !== 3'b101) begin
      n_bad++; $display("FAIL trig_any: got %b want 101", {trig_status, trig_any}); end
    trig_clr = 1'b1; trig_in = 2'b01;
    @(negedge clk);
    trig_clr = 1'b0; trig_in = 2'b00;
    n_cmp++; if (trig_status !== 2'b01) begin
      n_bad++; $display("FAIL trig_clr_set: got %b want 01", trig_status); end
    trig_clr = 1'b1;
    @(negedge clk);
    trig_clr = 1'b0;
    n_cmp++; if (trig_status !== 2'b00) begin
      n_bad++; $display("FAIL trig_clr: got %b want 00", trig_status); end
    // Idle: triggers ignored
    cfg_stop = 1'b1;
    @(negedge clk);
    cfg_stop = 1'b0;
    trig_in = 2'b11;
    @(negedge clk);
    @(negedge clk);
    trig_in = 2'b00;
    n_cmp++; if ({trig_status, trig_any, smu_en} !== 4'b0000) begin
      n_bad++; $display("FAIL trig_idle: got %b want 0000", {trig_status, trig_any, smu_en}); end
  endtask

  initial begin
    pat_a = {11'h213, 11'h5AF};
    pat_b = {11'h5AF, 11'h213};
    rst = 1'b1; cfg_start = 1'b0; cfg_stop = 1'b0; cfg_valid = 1'b0;
    cfg_data = 1'b0; trig_in = 2'b00; trig_clr = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_load();
    test_stalled_load();
    test_restart();
    test_stop_priority();
    test_triggers();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
